// File: rtl/out_reg_arbiter_if.sv
// Requester-to-arbiter handshake bus plus the shared output register view.
// The arbiter connects through the slave modport; the requesters and consumers use master.
interface out_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ*DATA_W-1:0] i_req_data;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [DATA_W-1:0]         o_out_reg_data;
    logic                      o_out_reg_wr;
    logic [ID_W-1:0]           o_grant_id;
    logic                      o_busy;

    modport slave (
        input  i_req_valid, i_req_data,
        output o_req_ready, o_out_reg_data, o_out_reg_wr, o_grant_id, o_busy
    );

    modport master (
        output i_req_valid, i_req_data,
        input  o_req_ready, o_out_reg_data, o_out_reg_wr, o_grant_id, o_busy
    );
endinterface

// File: rtl/out_reg_arbiter.sv
// Round-robin arbiter sharing one output data register between NUM_REQ requesters,
// holding each captured word for HOLD_CYCLES cycles before the next grant.
module out_reg_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                  i_CLK100MHZ,
    input  logic                  i_RST,
    out_reg_arbiter_if.slave      bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ID_W-1:0]     last_id_q;
    logic [ID_W-1:0]     grant_q;
    logic [DATA_W-1:0]   data_q;
    logic                wr_q;
    logic                busy_q;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     cand;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REQ-1:0]  req_ready;

    // Search starts just after the last winner, so the previous grant has lowest priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        win_data  = '0;
        req_ready = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_id_q) + i) % NUM_REQ);
            if (!win_found && bus.i_req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_id == ID_W'(k)) begin
                win_data = bus.i_req_data[k*DATA_W +: DATA_W];
            end
        end
        if (state_q == IDLE && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_CLK100MHZ) begin
        if (i_RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_id_q <= LAST_INIT;
            grant_q   <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        data_q    <= win_data;
                        wr_q      <= 1'b1;
                        grant_q   <= win_id;
                        last_id_q <= win_id;
                        if (HOLD_CYCLES > 0) begin
                            state_q <= HOLD;
                            cnt_q   <= HOLD_INIT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ready    = req_ready;
    assign bus.o_out_reg_data = data_q;
    assign bus.o_out_reg_wr   = wr_q;
    assign bus.o_grant_id     = grant_q;
    assign bus.o_busy         = busy_q;
endmodule
